// File: rtl/nrisc_pkg.sv
// Shared types and constants for the nRisc boot loader: loader states, default widths and
// frame layout constants.
package nrisc_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 8;

  // Fixed (non-payload) bytes in a frame: N_I, N_D and CHK.
  localparam int unsigned FrameOverhead = 3;
  localparam int unsigned ChecksumInit  = 0;

  typedef enum logic [2:0] {
    StCabI,
    StCargaI,
    StCabD,
    StCargaD,
    StChk,
    StFim,
    StErro
  } state_e;

endpackage

// File: rtl/porta_escrita_mem.sv
// Registered memory write port: captures address/data on a write request and presents them
// with a one-cycle strobe on the following cycle; address and data hold while idle.
module porta_escrita_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Reset wins over a request in the same cycle, suppressing the strobe that would follow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= we_i;
      if (we_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/carregador_programa.sv
// Boot loader: parses a framed byte stream into instruction and data memories, verifies the
// additive checksum and holds the nRisc core in reset until a frame loads cleanly.
module carregador_programa
  import nrisc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] InDado,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic                  Start,
  output logic [ADDR_WIDTH-1:0] InstrEndereco,
  output logic [DATA_WIDTH-1:0] InstrDado,
  output logic                  InstrWrite,
  output logic [ADDR_WIDTH-1:0] DadosEndereco,
  output logic [DATA_WIDTH-1:0] DadosDado,
  output logic                  DadosWrite,
  output logic                  CpuReset,
  output logic                  Pronto,
  output logic                  Erro
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic                  accept;
  logic                  last_byte;
  logic                  instr_we, dados_we;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StCabI;
      sum_q   <= DATA_WIDTH'(ChecksumInit);
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign InReady   = (state_q != StFim) && (state_q != StErro);
  assign accept    = InValid && InReady;
  assign last_byte = (cnt_q + 1'b1) == len_q;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    instr_we = 1'b0;
    dados_we = 1'b0;
    unique case (state_q)
      StCabI, StCabD: begin
        if (accept) begin
          sum_d = sum_q + InDado;
          len_d = ADDR_WIDTH'(InDado);
          cnt_d = '0;
          if (state_q == StCabI) begin
            state_d = (InDado == '0) ? StCabD : StCargaI;
          end else begin
            state_d = (InDado == '0) ? StChk : StCargaD;
          end
        end
      end
      StCargaI, StCargaD: begin
        if (accept) begin
          sum_d    = sum_q + InDado;
          cnt_d    = cnt_q + 1'b1;
          instr_we = (state_q == StCargaI);
          dados_we = (state_q == StCargaD);
          if (last_byte) begin
            state_d = (state_q == StCargaI) ? StCabD : StChk;
          end
        end
      end
      StChk: begin
        if (accept) begin
          state_d = (InDado == sum_q) ? StFim : StErro;
        end
      end
      StFim, StErro: begin
        if (Start) begin
          state_d = StCabI;
          sum_d   = DATA_WIDTH'(ChecksumInit);
        end
      end
      default: state_d = StCabI;
    endcase
  end

  assign CpuReset = (state_q != StFim);
  assign Pronto   = (state_q == StFim);
  assign Erro     = (state_q == StErro);

  porta_escrita_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_porta_instr (
    .clk_i (Clock),
    .rst_i (Reset),
    .we_i  (instr_we),
    .addr_i(cnt_q),
    .data_i(InDado),
    .we_o  (InstrWrite),
    .addr_o(InstrEndereco),
    .data_o(InstrDado)
  );

  porta_escrita_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_porta_dados (
    .clk_i (Clock),
    .rst_i (Reset),
    .we_i  (dados_we),
    .addr_i(cnt_q),
    .data_i(InDado),
    .we_o  (DadosWrite),
    .addr_o(DadosEndereco),
    .data_o(DadosDado)
  );

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: table of frames plus hand-written reset and
// re-arm sequences; memory writes are checked through an expected-write scoreboard.
module tb_carregador_programa;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] InDado;
  logic       InValid;
  logic       InReady;
  logic       Start;
  logic [7:0] InstrEndereco, InstrDado, DadosEndereco, DadosDado;
  logic       InstrWrite, DadosWrite, CpuReset, Pronto, Erro;

  carregador_programa #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .InDado       (InDado),
    .InValid      (InValid),
    .InReady      (InReady),
    .Start        (Start),
    .InstrEndereco(InstrEndereco),
    .InstrDado    (InstrDado),
    .InstrWrite   (InstrWrite),
    .DadosEndereco(DadosEndereco),
    .DadosDado    (DadosDado),
    .DadosWrite   (DadosWrite),
    .CpuReset     (CpuReset),
    .Pronto       (Pronto),
    .Erro         (Erro)
  );

  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        dmem;
    logic [7:0]  addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_t;

  wr_t sb[$];

  typedef struct {
    logic [0:7][7:0] f;
    int              n;
    bit              gaps;
    bit              ok;
    int              start_at;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write, including its cycle.
  always @(negedge Clock) begin
    if (InstrWrite === 1'b1 || DadosWrite === 1'b1) begin
      wr_t act, e;
      act = '{dmem: DadosWrite, addr: DadosWrite ? DadosEndereco : InstrEndereco,
              data: DadosWrite ? DadosDado : InstrDado, cyc: cyc};
      tests++;
      if (InstrWrite === 1'b1 && DadosWrite === 1'b1) begin
        fails++;
        $display("FAIL both_strobes: instr and data strobes high together at cycle %0d", cyc);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got dmem=%0d addr=%0h data=%0h cyc=%0d, none expected",
                 act.dmem, act.addr, act.data, act.cyc);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL mem_write: got dmem=%0d addr=%0h data=%0h cyc=%0d expected dmem=%0d addr=%0h data=%0h cyc=%0d",
                   act.dmem, act.addr, act.data, act.cyc, e.dmem, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Drives one byte for one cycle; the loader must be ready for it.
  task automatic send(input logic [7:0] b, input bit st);
    InDado  = b;
    InValid = 1'b1;
    Start   = st;
    @(negedge Clock);
    chk("in_ready_while_loading", InReady, 1'b1);
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    Start   = 1'b0;
  endtask

  task automatic idle(input int cycles);
    InValid = 1'b0;
    InDado  = 8'hFF;
    repeat (cycles) @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic dmem, input int idx, input logic [7:0] b);
    sb.push_back('{dmem: dmem, addr: 8'(idx), data: b, cyc: cyc + 1});
  endtask

  task automatic send_frame(input logic [0:7][7:0] f, input int n, input bit gaps,
                            input int start_at);
    int ni, nd;
    ni = int'(f[0]);
    nd = int'(f[ni + 1]);
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0) idle(1);
      if (k >= 1 && k <= ni) push(1'b0, k - 1, f[k]);
      else if (k >= ni + 2 && k < ni + 2 + nd) push(1'b1, k - ni - 2, f[k]);
      send(f[k], k == start_at);
    end
  endtask

  task automatic rearm(input string tag);
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    chk({tag, "_rearm_pronto"}, Pronto, 1'b0);
    chk({tag, "_rearm_erro"}, Erro, 1'b0);
    chk({tag, "_rearm_cpureset"}, CpuReset, 1'b1);
    chk({tag, "_rearm_inready"}, InReady, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{f: {8'h03, 8'h11, 8'h22, 8'h33, 8'h02, 8'h0A, 8'h0B, 8'h80}, n: 8,
                gaps: 1'b0, ok: 1'b1, start_at: -1};
    vecs[1] = '{f: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 3,
                gaps: 1'b0, ok: 1'b1, start_at: -1};
    vecs[2] = '{f: {8'h03, 8'h11, 8'h22, 8'h33, 8'h02, 8'h0A, 8'h0B, 8'h7F}, n: 8,
                gaps: 1'b0, ok: 1'b0, start_at: -1};
    vecs[3] = '{f: {8'h03, 8'h11, 8'h22, 8'h33, 8'h02, 8'h0A, 8'h0B, 8'h80}, n: 8,
                gaps: 1'b1, ok: 1'b1, start_at: -1};
    vecs[4] = '{f: {8'h00, 8'h01, 8'h55, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4,
                gaps: 1'b0, ok: 1'b1, start_at: -1};
    vecs[5] = '{f: {8'h01, 8'hAA, 8'h00, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4,
                gaps: 1'b0, ok: 1'b1, start_at: -1};
    // Start pulsed alongside the second data byte, while in CARGA_D.
    vecs[6] = '{f: {8'h03, 8'h11, 8'h22, 8'h33, 8'h02, 8'h0A, 8'h0B, 8'h80}, n: 8,
                gaps: 1'b0, ok: 1'b1, start_at: 6};

    Reset   = 1'b1;
    Start   = 1'b0;
    InValid = 1'b0;
    InDado  = 8'h00;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_cpureset", CpuReset, 1'b1);
    chk("reset_pronto", Pronto, 1'b0);
    chk("reset_erro", Erro, 1'b0);
    chk("reset_strobes", {InstrWrite, DadosWrite}, 2'b00);
    chk("reset_addr_data", {InstrEndereco, InstrDado, DadosEndereco, DadosDado}, 32'h0);
    Reset = 1'b0;
    chk("reset_inready", InReady, 1'b1);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].f, vecs[i].n, vecs[i].gaps, vecs[i].start_at);
      chk($sformatf("v%0d_pronto", i), Pronto, vecs[i].ok);
      chk($sformatf("v%0d_erro", i), Erro, !vecs[i].ok);
      chk($sformatf("v%0d_cpureset", i), CpuReset, !vecs[i].ok);
      chk($sformatf("v%0d_inready_done", i), InReady, 1'b0);
      idle(2);
      chk($sformatf("v%0d_hold_pronto", i), Pronto, vecs[i].ok);
      chk($sformatf("v%0d_hold_erro", i), Erro, !vecs[i].ok);
      chk($sformatf("v%0d_sb_drained", i), sb.size(), 0);
      rearm($sformatf("v%0d", i));
    end

    // Reset mid-load; the byte offered alongside Reset must not produce a write.
    send(8'h03, 1'b0);
    push(1'b0, 0, 8'h11);
    send(8'h11, 1'b0);
    push(1'b0, 1, 8'h22);
    send(8'h22, 1'b0);
    InDado  = 8'h33;
    InValid = 1'b1;
    Reset   = 1'b1;
    Start   = 1'b1;
    @(posedge Clock);
    #1;
    Reset   = 1'b0;
    Start   = 1'b0;
    InValid = 1'b0;
    chk("midrst_instr_write", InstrWrite, 1'b0);
    chk("midrst_instr_addr_data", {InstrEndereco, InstrDado}, 16'h0);
    chk("midrst_cpureset", CpuReset, 1'b1);
    chk("midrst_pronto", Pronto, 1'b0);
    chk("midrst_inready", InReady, 1'b1);
    idle(2);
    chk("midrst_sb_drained", sb.size(), 0);
    send_frame(vecs[0].f, vecs[0].n, 1'b0, -1);
    chk("after_rst_pronto", Pronto, 1'b1);
    chk("after_rst_cpureset", CpuReset, 1'b0);
    idle(2);
    chk("final_sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
Name: carregador_programa

Overview:
- Boot loader sitting directly upstream of the instruction and data memories and the nRisc core.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload into instruction memory and then data memory, starting at address 0 in each.
- Verifies an 8-bit additive checksum over the whole frame.
- Holds the core in reset until a frame loads cleanly, then releases it.

Parameters:
- DATA_WIDTH, 8, byte/word width of stream and memory data.
- ADDR_WIDTH, 8, memory address width; also the width of the length fields and counters.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- InDado  in  DATA_WIDTH  incoming stream byte.
- InValid  in  1  InDado is valid this cycle.
- InReady  out  1  loader can accept a byte this cycle.
- Start  in  1  re-arm pulse; honoured only in FIM or ERRO.
- InstrEndereco  out  ADDR_WIDTH  instruction memory write address.
- InstrDado  out  DATA_WIDTH  instruction memory write data.
- InstrWrite  out  1  instruction memory write strobe, one cycle per byte.
- DadosEndereco  out  ADDR_WIDTH  data memory write address.
- DadosDado  out  DATA_WIDTH  data memory write data.
- DadosWrite  out  1  data memory write strobe, one cycle per byte.
- CpuReset  out  1  reset to the nRisc core; high while not loaded.
- Pronto  out  1  frame loaded and checksum correct.
- Erro  out  1  checksum mismatch.

Behaviour:
- Frame format: N_I, N_I instruction bytes, N_D, N_D data bytes, CHK.
  - N_I and N_D range 0..255.
  - CHK is the sum modulo 256 of every preceding frame byte, including both length bytes.
- Transfer occurs on any cycle where InValid and InReady are both high.
- InReady is combinational from state: high in CAB_I, CARGA_I, CAB_D, CARGA_D, CHK; low in FIM and ERRO.
- States and transitions:
  - CAB_I: accept N_I; go to CARGA_I, or to CAB_D if N_I = 0.
  - CARGA_I: accept payload bytes; leave for CAB_D when the N_I-th byte is accepted.
  - CAB_D: accept N_D; go to CARGA_D, or to CHK if N_D = 0.
  - CARGA_D: accept payload bytes; leave for CHK when the N_D-th byte is accepted.
  - CHK: accept the checksum byte; go to FIM on match, ERRO on mismatch.
  - FIM and ERRO: hold until Start = 1, then go to CAB_I.
- Every accepted byte, including N_I and N_D, is added to the running sum. The CHK byte itself is not added.
- Memory writes are registered:
  - A payload byte accepted at cycle t produces InstrWrite or DadosWrite = 1 at cycle t+1, with address = index (0-based) and data = the byte.
  - The strobe is high for exactly one cycle.
  - Address and data outputs hold their last value when the strobe is low.
- The index counter resets to 0 on entering CARGA_I and on entering CARGA_D.
- Idle gaps (InValid low) stall the loader without changing state or counters. There is no timeout.
- CpuReset is high in every state except FIM; it goes low the cycle after FIM is entered.
- Pronto = 1 exactly when in FIM. Erro = 1 exactly when in ERRO.
- On Start from FIM or ERRO:
  - next cycle: state CAB_I, sum = 0, CpuReset = 1, Pronto = 0, Erro = 0.
  - Previously written memory contents are not cleared.
- Start in any other state is ignored.
- Reset, at any time including mid-load:
  - state CAB_I, sum = 0, counters = 0, CpuReset = 1, Pronto = 0, Erro = 0.
  - InstrWrite = 0, DadosWrite = 0; addresses and data = 0.
  - A write strobe that would have fired the cycle after Reset is suppressed.
  - Partially written memory is left as is.
- Simultaneous Reset and Start: Reset wins.
- All arithmetic is modulo 2^DATA_WIDTH; counters never exceed 255.

Decomposition:
- Shared package (nrisc_pkg):
  - state enum (CAB_I, CARGA_I, CAB_D, CARGA_D, CHK, FIM, ERRO);
  - DATA_WIDTH and ADDR_WIDTH defaults;
  - frame-field constants.
- One natural sub-module, porta_escrita_mem: a registered write port (address/data/strobe) instantiated twice, for instruction and data memory. The FSM, counter and checksum stay in the top module.

Test Plan:
- Nominal frame: stream 03,11,22,33,02,0A,0B,80 with InValid held high.
  - Instruction writes (0,11),(1,22),(2,33) and data writes (0,0A),(1,0B), each one cycle after acceptance.
  - Pronto = 1 and CpuReset = 0 after the 80 is accepted.
- Empty frame: stream 00,00,00.
  - No write strobes; FIM reached after 3 transfers; CpuReset falls.
- Bad checksum: stream 03,11,22,33,02,0A,0B,7F.
  - All five writes occur; ERRO with Erro = 1, CpuReset stays 1, InReady = 0.
  - Pulse Start: returns to CAB_I with Erro = 0.
- Backpressure/gaps: the nominal frame with InValid toggled every other cycle.
  - Identical writes and result; no byte is double-counted during InValid = 0 cycles.
- Reset mid-load: assert Reset after the 2nd instruction byte.
  - Next cycle: CAB_I, no pending strobe fires, CpuReset = 1.
  - Then the nominal frame loads correctly.
- Start outside FIM/ERRO: pulse Start during CARGA_D.
  - No effect; the frame completes to FIM.
